store_tank: RTL and testbench

STORE_TANK -- requirements
Module: store_tank

---
 rtl/store_tank_if.sv | 39 +++
 rtl/store_tank.sv | 139 +++++++++++++
 tb/tb_store_tank.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/store_tank_if.sv
// store_tank_if -- digit timing, request handshake and serial buses of the
// store tank. Optional write-protect signals appear when TANK_WPROT_EN is
// defined.
interface store_tank_if;
    logic       d0;       // first digit of the minor cycle
    logic       d35;      // last digit of the minor cycle
    logic       req;      // transfer request
    logic       wr;       // 1 = write (mob -> store), 0 = read (store -> mib)
    logic       long_w;   // 1 = 35-bit long word, 0 = 17-bit short word
    logic [4:0] addr;     // short-word address
    logic       mob;      // serial data from the computer
    logic       mib;      // serial data to the computer
    logic       busy;     // transfer pending or active
    logic       done;     // transfer-complete pulse
`ifdef TANK_WPROT_EN
    logic       wprot;    // write protect, sampled with the request
    logic       wp_err;   // protected write attempted, pulses with done
`endif

    // Store side
    modport slave (
        input  d0, d35, req, wr, long_w, addr, mob,
`ifdef TANK_WPROT_EN
        input  wprot,
        output wp_err,
`endif
        output mib, busy, done
    );

    // Computer side
    modport master (
        output d0, d35, req, wr, long_w, addr, mob,
`ifdef TANK_WPROT_EN
        output wprot,
        input  wp_err,
`endif
        input  mib, busy, done
    );
endinterface

// File: rtl/store_tank.sv
// store_tank -- 32 x 18-bit serial store (17 word bits + sandwich digit).
// One transfer at a time: a request arms the tank, the next d0..d35 minor
// cycle carries 36 digits LSB first, and writes commit on the d35 edge.
// Optional feature macro: TANK_WPROT_EN (write protect input, wp_err output).
module store_tank (
    input  logic          clk,
    input  logic          rst_n,
    store_tank_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ARMED, XFER} state_t;

    state_t      state_q, state_d;
    logic        wr_q, long_q;
    logic [4:0]  addr_q;
    logic [35:0] rsreg_q;      // read shift register, digit n at bit 0 in window cycle n
    logic [34:0] wsreg_q;      // write capture, digit n lands at bit n after d34
    logic        done_q;

    // Store split into even/odd banks so a long word touches one row of each
    logic [17:0] even_q [16];
    logic [17:0] odd_q  [16];

    logic        accept, window, finish, commit;
    logic [3:0]  rrow, wrow;
    logic [16:0] short_sel;
    logic [35:0] snap;

`ifdef TANK_WPROT_EN
    logic        wprot_q;
    logic        wp_err_q;
`endif

    assign accept = (state_q == IDLE) && bus.req;
    // Window: the d0 cycle while armed, then every XFER cycle through d35
    assign window = ((state_q == ARMED) && bus.d0) || (state_q == XFER);
    assign finish = (state_q == XFER) && bus.d35;

`ifdef TANK_WPROT_EN
    assign commit = finish && wr_q && !wprot_q;
`else
    assign commit = finish && wr_q;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a request is only seen in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req) state_d = ARMED;
            ARMED:   if (bus.d0)  state_d = XFER;
            XFER:    if (bus.d35) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the request fields at acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= 1'b0;
            long_q <= 1'b0;
            addr_q <= '0;
        end else if (accept) begin
            wr_q   <= bus.wr;
            long_q <= bus.long_w;
            addr_q <= bus.addr;
        end
    end

    // Read snapshot built from the incoming request, taken at ARMED entry
    always_comb begin
        rrow      = bus.addr[4:1];
        short_sel = bus.addr[0] ? odd_q[rrow][16:0] : even_q[rrow][16:0];
        if (bus.long_w) snap = {1'b0, odd_q[rrow][16:0], even_q[rrow]};
        else            snap = {19'b0, short_sel};
    end

    // Read shift register: loaded on accept (zero for writes), shifts in window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rsreg_q <= '0;
        else if (accept) rsreg_q <= bus.wr ? 36'b0 : snap;
        else if (window) rsreg_q <= {1'b0, rsreg_q[35:1]};
    end

    assign bus.mib = rsreg_q[0] & window;

    // Write capture: mob sampled every window edge; the d35 sample is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      wsreg_q <= '0;
        else if (window) wsreg_q <= {bus.mob, wsreg_q[34:1]};
    end

    assign wrow = addr_q[4:1];

    // Store array: not reset; commits only on a completed write's d35 edge
    always_ff @(posedge clk) begin
        if (commit) begin
            if (long_q) begin
                even_q[wrow] <= wsreg_q[17:0];
                odd_q[wrow]  <= {1'b0, wsreg_q[34:18]};
            end else if (addr_q[0]) begin
                odd_q[wrow]  <= {1'b0, wsreg_q[16:0]};
            end else begin
                even_q[wrow] <= {1'b0, wsreg_q[16:0]};
            end
        end
    end

    // done pulses for the cycle after the d35 edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= finish;
    end

    assign bus.done = done_q;
    assign bus.busy = (state_q != IDLE);

`ifdef TANK_WPROT_EN
    // Protect flag is captured with the request so it covers the whole transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      wprot_q <= 1'b0;
        else if (accept) wprot_q <= bus.wprot;
    end

    // Blocked-write error pulses alongside done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wp_err_q <= 1'b0;
        else        wp_err_q <= finish && wr_q && wprot_q;
    end

    assign bus.wp_err = wp_err_q;
`endif

endmodule

// File: tb/tb_store_tank.sv
// tb_store_tank -- directed bench for store_tank. The bench owns the digit
// counter (d0/d35), drives inputs 1 time unit after the rising edge and
// samples outputs on the falling edge.
module tb_store_tank;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    store_tank_if bus ();
    store_tank dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_run  = 0;
    int n_fail = 0;
    int digit  = 0;

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Advance one digit and drive d0/d35 for the new cycle
    task automatic next_cycle();
        @(posedge clk);
        #1;
        digit    = (digit == 35) ? 0 : digit + 1;
        bus.d0   = (digit == 0);
        bus.d35  = (digit == 35);
    endtask

    // Leave the bench so that the next next_cycle() lands on digit dg
    task automatic wait_digit(input int dg);
        for (int i = 0; i < 40 && digit != ((dg + 35) % 36); i++) next_cycle();
    endtask

    // One complete transfer with protocol checks; request goes out on cycle k=0
    task automatic xfer(input string nm, input logic w, input logic l, input logic [4:0] a,
                        input logic [35:0] wd, input logic wp, input logic stray,
                        output logic [35:0] rd, output int start_k, output int done_k);
        int   wcyc, dn, bad, bsy, end_k, wpe, wpe_bad;
        logic inwin;
        wcyc = 0; dn = 0; bad = 0; bsy = 0; end_k = -1; wpe = 0; wpe_bad = 0;
        inwin = 1'b0; rd = '0; start_k = -1; done_k = -1;
        for (int k = 0; k < 120; k++) begin
            next_cycle();
            bus.req    = (k == 0) || (stray && inwin && digit == 10);
            bus.wr     = w;
            bus.long_w = l;
            bus.addr   = a;
            bus.mob    = wd[digit];
`ifdef TANK_WPROT_EN
            bus.wprot  = wp;
`endif
            @(negedge clk);
            if (k > 0 && end_k < 0 && !inwin && bus.d0) begin
                inwin   = 1'b1;
                start_k = k;
            end
            if (inwin) begin
                rd[digit] = bus.mib;
                wcyc++;
            end else if (bus.mib !== 1'b0) begin
                bad++;
            end
            if (bus.busy !== (k > 0 && end_k < 0)) bsy++;
            if (bus.done === 1'b1) begin
                dn++;
                done_k = k;
            end
`ifdef TANK_WPROT_EN
            if (bus.wp_err === 1'b1) begin
                wpe++;
                if (bus.done !== 1'b1) wpe_bad++;
            end
`endif
            if (inwin && bus.d35) begin
                inwin = 1'b0;
                end_k = k;
            end
            if (end_k >= 0 && k >= end_k + 3) break;
        end
        bus.req = 1'b0;
        chk({nm, "/ended"},   36'(end_k >= 0), 36'd1);
        chk({nm, "/win_len"}, 36'(wcyc), 36'd36);
        chk({nm, "/done_n"},  36'(dn), 36'd1);
        chk({nm, "/done_at"}, 36'(done_k - end_k), 36'd1);
        chk({nm, "/mib_out"}, 36'(bad), 36'd0);
        chk({nm, "/busy"},    36'(bsy), 36'd0);
`ifdef TANK_WPROT_EN
        chk({nm, "/wp_err_n"},   36'(wpe), 36'(w && wp));
        chk({nm, "/wp_err_at"},  36'(wpe_bad), 36'd0);
`else
        if (wp) chk({nm, "/wp_unused"}, 36'(w), 36'd0);
`endif
    endtask

    task automatic do_wr(input string nm, input logic l, input logic [4:0] a,
                         input logic [35:0] wd, input logic wp);
        logic [35:0] rd;
        int sk, dk;
        xfer(nm, 1'b1, l, a, wd, wp, 1'b0, rd, sk, dk);
        chk({nm, "/mib"}, rd, 36'd0);
    endtask

    task automatic do_rd(input string nm, input logic l, input logic [4:0] a,
                         input logic [35:0] exp, input logic stray);
        logic [35:0] rd;
        int sk, dk;
        xfer(nm, 1'b0, l, a, 36'd0, 1'b0, stray, rd, sk, dk);
        chk({nm, "/data"}, rd, exp);
    endtask

    logic [35:0] rdv;
    int          sk, dk, dn;
    logic        seen, aborted;

    initial begin
        rst_n      = 1'b0;
        bus.d0     = 1'b1;
        bus.d35    = 1'b0;
        bus.req    = 1'b0;
        bus.wr     = 1'b0;
        bus.long_w = 1'b0;
        bus.addr   = '0;
        bus.mob    = 1'b0;
`ifdef TANK_WPROT_EN
        bus.wprot  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst/busy", 36'(bus.busy), 36'd0);
        chk("rst/done", 36'(bus.done), 36'd0);
        chk("rst/mib",  36'(bus.mib),  36'd0);
`ifdef TANK_WPROT_EN
        chk("rst/wp_err", 36'(bus.wp_err), 36'd0);
`endif
        next_cycle();
        rst_n = 1'b1;

        // Short write; upper digits carry ones that must be ignored
        wait_digit(5);
        do_wr("w5", 1'b0, 5'd5, {19'h7FFFF, 17'h0A5A5}, 1'b0);
        wait_digit(12);
        do_rd("r5", 1'b0, 5'd5, {19'h0, 17'h0A5A5}, 1'b0);

        // Short write with digit 17 set: sandwich bit must land as 0
        do_wr("w4", 1'b0, 5'd4, 36'hF_FFFF_FFFF, 1'b0);
        do_rd("rl5", 1'b1, 5'd5, {1'b0, 17'h0A5A5, 18'h1FFFF}, 1'b0);

        // Long write to addr 7 (digit 35 set, must be discarded)
        do_wr("wl7", 1'b1, 5'd7, {1'b1, 35'h2_3456_789A}, 1'b0);
        do_rd("rl6", 1'b1, 5'd6, {1'b0, 35'h2_3456_789A}, 1'b0);
        do_rd("r6",  1'b0, 5'd6, 36'h0_0000_789A, 1'b0);
        do_rd("r7",  1'b0, 5'd7, 36'h0_0000_8D15, 1'b0);

        // Request on the d0 cycle: transfer waits for the next full window
        wait_digit(0);
        xfer("req_d0", 1'b0, 1'b0, 5'd5, 36'd0, 1'b0, 1'b0, rdv, sk, dk);
        chk("req_d0/start", 36'(sk), 36'd36);
        chk("req_d0/done",  36'(dk), 36'd72);
        chk("req_d0/data",  rdv, {19'h0, 17'h0A5A5});

        // Reset in the middle of a long write: store must be untouched
        do_wr("wl2", 1'b1, 5'd2, {1'b0, 35'h1_2345_6789}, 1'b0);
        wait_digit(5);
        next_cycle();
        bus.req = 1'b1; bus.wr = 1'b1; bus.long_w = 1'b1; bus.addr = 5'd2;
        seen = 1'b0; aborted = 1'b0;
        for (int k = 0; k < 80 && !aborted; k++) begin
            next_cycle();
            bus.req = 1'b0;
            bus.mob = ~bus.mob;
            if (digit == 0) seen = 1'b1;
            if (seen && digit == 20) begin
                rst_n   = 1'b0;
                aborted = 1'b1;
            end
        end
        @(negedge clk);
        chk("abort/hit",  36'(aborted), 36'd1);
        chk("abort/busy", 36'(bus.busy), 36'd0);
        chk("abort/mib",  36'(bus.mib),  36'd0);
        dn = 0;
        for (int k = 0; k < 44; k++) begin
            next_cycle();
            if (k == 3) rst_n = 1'b1;
            @(negedge clk);
            if (bus.done === 1'b1) dn++;
        end
        chk("abort/no_done", 36'(dn), 36'd0);
        do_rd("rl2_after", 1'b1, 5'd2, {1'b0, 35'h1_2345_6789}, 1'b0);

        // Stray request during a read window is ignored
        do_rd("rl6_stray", 1'b1, 5'd6, {1'b0, 35'h2_3456_789A}, 1'b1);

`ifdef TANK_WPROT_EN
        // Protected write runs its timing but leaves the store alone
        do_wr("w0", 1'b0, 5'd0, 36'h0_0000_0123, 1'b0);
        do_wr("w0_prot", 1'b0, 5'd0, 36'h0_0001_FFFF, 1'b1);
        do_rd("r0", 1'b0, 5'd0, 36'h0_0000_0123, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
